dm_access_unit: RTL and testbench

Initiator side of the 4 KB byte-enabled data memory port. Accepts one load/store request at a time from the pipeline MEM stage and drives the memory's word address, byte enables, write data and write strobe. Splits misaligned halfword/word accesses into single-byte beats. Returns load data with lane extraction and sign/zero extension.

---
 rtl/dm_access_pkg.sv | 32 +++
 rtl/dm_load_align.sv | 26 ++
 rtl/dm_access_unit.sv | 149 ++++++++++++++
 tb/tb_dm_access_unit.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_access_pkg.sv
// Shared encodings and helpers for the data-memory access unit.
package dm_access_pkg;

   localparam logic [1:0] SZ_BYTE    = 2'b00;
   localparam logic [1:0] SZ_HALF    = 2'b01;
   localparam logic [1:0] SZ_WORD    = 2'b10;
   localparam logic [1:0] SZ_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   localparam logic [3:0] BE_B0  = 4'b0001;
   localparam logic [3:0] BE_B1  = 4'b0010;
   localparam logic [3:0] BE_B2  = 4'b0100;
   localparam logic [3:0] BE_B3  = 4'b1000;
   localparam logic [3:0] BE_LO  = 4'b0011;
   localparam logic [3:0] BE_HI  = 4'b1100;
   localparam logic [3:0] BE_ALL = 4'b1111;

   function automatic logic [2:0] bytes_of(input logic [1:0] size);
      case (size)
         SZ_BYTE: bytes_of = 3'd1;
         SZ_HALF: bytes_of = 3'd2;
         SZ_WORD: bytes_of = 3'd4;
         default: bytes_of = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/dm_load_align.sv
// Load lane select and sign/zero extension to a 32-bit result.
module dm_load_align
   import dm_access_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        uns,
   output logic [31:0] data
);

   logic [7:0]  b;
   logic [15:0] h;

   assign b = word[{off, 3'b000} +: 8];
   assign h = off[1] ? word[31:16] : word[15:0];

   always_comb begin
      case (size)
         SZ_BYTE: data = {{24{b[7] & ~uns}}, b};
         SZ_HALF: data = {{16{h[15] & ~uns}}, h};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory initiator: one request at a time, misaligned accesses split
// into byte beats, load data extracted and extended on completion.
module dm_access_unit
   import dm_access_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-3:0] dm_addr,
   output logic [3:0]        dm_be,
   output logic [DATA_W-1:0] dm_din,
   output logic              dm_we,
   input  logic [DATA_W-1:0] dm_dout
);

   localparam int AW1 = ADDR_W + 1;

   state_e            state;
   logic              r_we;
   logic [1:0]        r_size;
   logic              r_uns;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_mis;
   logic [1:0]        beat;
   logic [1:0]        last;
   logic [DATA_W-1:0] acc;

   logic              req_bad;
   logic              req_mis;
   logic [ADDR_W-1:0] a;
   logic [DATA_W-1:0] merged;
   logic [DATA_W-1:0] align_in;
   logic [1:0]        align_off;
   logic [DATA_W-1:0] ld_data;

   // addr + bytes - 1 > top-of-space, evaluated one bit wider to catch the carry
   assign req_bad = (req_size == SZ_ILLEGAL) ||
                    (({1'b0, req_addr} + AW1'(bytes_of(req_size))) > AW1'(1 << ADDR_W));
   assign req_mis = ((req_size == SZ_HALF) && req_addr[0]) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

   assign a = r_mis ? r_addr + ADDR_W'(beat) : r_addr;

   always_comb begin
      merged = acc;
      merged[{beat, 3'b000} +: 8] = dm_dout[{a[1:0], 3'b000} +: 8];
   end

   // Misaligned loads are already assembled right-aligned, so only extend them
   assign align_in  = r_mis ? merged : dm_dout;
   assign align_off = r_mis ? 2'b00 : r_addr[1:0];

   dm_load_align u_align (
      .word (align_in),
      .off  (align_off),
      .size (r_size),
      .uns  (r_uns),
      .data (ld_data)
   );

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);

   always_comb begin
      dm_addr = '0;
      dm_be   = '0;
      dm_din  = '0;
      dm_we   = 1'b0;
      if (state == ACCESS) begin
         dm_addr = a[ADDR_W-1:2];
         // A beat coinciding with reset is dropped rather than committed
         dm_we   = r_we & ~rst;
         if (!r_mis && r_size == SZ_WORD) begin
            dm_be  = BE_ALL;
            dm_din = r_wdata;
         end else if (!r_mis && r_size == SZ_HALF) begin
            dm_be        = a[1] ? BE_HI : BE_LO;
            dm_din[15:0] = r_wdata[15:0];
         end else begin
            dm_be       = BE_B0 << a[1:0];
            dm_din[7:0] = r_wdata[{beat, 3'b000} +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         r_we      <= 1'b0;
         r_size    <= SZ_BYTE;
         r_uns     <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_mis     <= 1'b0;
         beat      <= '0;
         last      <= '0;
         acc       <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               r_we    <= req_we;
               r_size  <= req_size;
               r_uns   <= req_unsigned;
               r_addr  <= req_addr;
               r_wdata <= req_wdata;
               r_mis   <= req_mis;
               beat    <= '0;
               acc     <= '0;
               last    <= !req_mis ? 2'd0 : (req_size == SZ_WORD) ? 2'd3 : 2'd1;
               if (req_bad) begin
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  state     <= RESP;
               end else begin
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               acc <= merged;
               if (beat == last) begin
                  rsp_err   <= 1'b0;
                  rsp_rdata <= r_we ? '0 : ld_data;
                  state     <= RESP;
               end else begin
                  beat <= beat + 2'd1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: byte-array memory, byte-level reference model.
module tb_dm_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [11:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [9:0]  dm_addr;
   logic [3:0]  dm_be;
   logic [31:0] dm_din;
   logic        dm_we;
   logic [31:0] dm_dout;

   dm_access_unit dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dm_addr(dm_addr),
      .dm_be(dm_be), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
   );

   always #5 clk = ~clk;

   logic [7:0] tb_mem  [4096] = '{default: 8'h00};
   logic [7:0] ref_mem [4096] = '{default: 8'h00};
   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory steers right-aligned write data into the enabled lanes
   assign dm_dout = {tb_mem[{dm_addr, 2'd3}], tb_mem[{dm_addr, 2'd2}],
                     tb_mem[{dm_addr, 2'd1}], tb_mem[{dm_addr, 2'd0}]};
   always @(posedge clk) begin
      if (dm_we) begin
         case (dm_be)
            4'b1111: begin
               tb_mem[{dm_addr, 2'd0}] <= dm_din[7:0];
               tb_mem[{dm_addr, 2'd1}] <= dm_din[15:8];
               tb_mem[{dm_addr, 2'd2}] <= dm_din[23:16];
               tb_mem[{dm_addr, 2'd3}] <= dm_din[31:24];
            end
            4'b0011: begin
               tb_mem[{dm_addr, 2'd0}] <= dm_din[7:0];
               tb_mem[{dm_addr, 2'd1}] <= dm_din[15:8];
            end
            4'b1100: begin
               tb_mem[{dm_addr, 2'd2}] <= dm_din[7:0];
               tb_mem[{dm_addr, 2'd3}] <= dm_din[15:8];
            end
            4'b0001: tb_mem[{dm_addr, 2'd0}] <= dm_din[7:0];
            4'b0010: tb_mem[{dm_addr, 2'd1}] <= dm_din[7:0];
            4'b0100: tb_mem[{dm_addr, 2'd2}] <= dm_din[7:0];
            4'b1000: tb_mem[{dm_addr, 2'd3}] <= dm_din[7:0];
            default: ;
         endcase
      end
   end

   logic [9:0]  q_addr [$];
   logic [3:0]  q_be   [$];
   logic [31:0] q_din  [$];
   int          n_we;

   // Byte-addressed model: stores write bytes addr..addr+n-1, loads read them back
   task automatic ref_model(input logic we, input logic [1:0] size, input logic uns,
                            input logic [11:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err, output int lat);
      int n, a;
      logic [31:0] v;
      n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : (size == 2'b10) ? 4 : 0;
      a = int'(addr);
      rd = '0;
      v = '0;
      err = (n == 0) || (a + n > 4096);
      if (err) begin
         lat = 1;
         return;
      end
      lat = (a % n != 0) ? n + 1 : 2;
      if (we) begin
         for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
      end else begin
         for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + i];
         if (n == 1 && !uns) v = {{24{v[7]}}, v[7:0]};
         if (n == 2 && !uns) v = {{16{v[15]}}, v[15:0]};
         rd = v;
      end
   endtask

   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [11:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int lat,
                         output int waited, output int acc_cyc);
      q_addr.delete(); q_be.delete(); q_din.delete();
      n_we = 0; waited = 0; lat = -1; rd = '0; err = 1'b0;
      @(negedge clk);
      while (!req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      @(posedge clk);
      acc_cyc = cyc;
      #1;
      req_valid = 1'b0; req_we = $urandom_range(0, 1); req_size = 2'($urandom);
      req_unsigned = $urandom_range(0, 1); req_addr = 12'($urandom); req_wdata = $urandom;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (dm_be != 4'b0000 || dm_we) begin
            q_addr.push_back(dm_addr); q_be.push_back(dm_be); q_din.push_back(dm_din);
            if (dm_we) n_we++;
         end
         if (rsp_valid) begin
            lat = c; rd = rsp_rdata; err = rsp_err;
            break;
         end
      end
   endtask

   logic [31:0] g_rd, e_rd;
   logic        g_err, e_err;
   int          g_lat, e_lat, g_wait, g_acc;

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n_tests++;
      if ({req_ready, rsp_valid, rsp_err, dm_we} !== 4'b1000) begin
         n_fail++; $display("FAIL reset_ctl got %b want 1000", {req_ready, rsp_valid, rsp_err, dm_we});
      end
      n_tests++;
      if (rsp_rdata !== 32'h0) begin
         n_fail++; $display("FAIL reset_rdata got %h want 0", rsp_rdata);
      end
      n_tests++;
      if ({dm_addr, dm_be, dm_din} !== 46'h0) begin
         n_fail++; $display("FAIL reset_dm got addr %h be %b din %h want 0", dm_addr, dm_be, dm_din);
      end
   endtask

   task automatic test_aligned();
      ref_model(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, e_rd, e_err, e_lat);
      do_req(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, g_rd, g_err, g_lat, g_wait, g_acc);
      n_tests++;
      if (q_be.size() != 1) begin
         n_fail++; $display("FAIL aligned_st_beats got %0d want 1", q_be.size());
      end else if ({q_be[0], q_addr[0], q_din[0]} !== {4'b1111, 10'h004, 32'hDEADBEEF}) begin
         n_fail++; $display("FAIL aligned_st_beat got be %b addr %h din %h want 1111 004 deadbeef", q_be[0], q_addr[0], q_din[0]);
      end
      ref_model(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, e_rd, e_err, e_lat);
      do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, g_rd, g_err, g_lat, g_wait, g_acc);
      n_tests++;
      if (g_rd !== 32'hDEADBEEF || g_err !== 1'b0) begin
         n_fail++; $display("FAIL aligned_ld_data got %h err %b want deadbeef 0", g_rd, g_err);
      end
      n_tests++;
      if (g_lat != 2) begin
         n_fail++; $display("FAIL aligned_ld_latency got %0d want 2", g_lat);
      end
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL rsp_pulse_width got %b want 0", rsp_valid);
      end
   endtask

   task automatic test_byte();
      ref_model(1'b1, 2'b00, 1'b0, 12'h013, 32'h80, e_rd, e_err, e_lat);
      do_req(1'b1, 2'b00, 1'b0, 12'h013, 32'h80, g_rd, g_err, g_lat, g_wait, g_acc);
      n_tests++;
      if (q_be.size() != 1) begin
         n_fail++; $display("FAIL byte_st_beats got %0d want 1", q_be.size());
      end else if ({q_be[0], q_din[0]} !== {4'b1000, 32'h00000080}) begin
         n_fail++; $display("FAIL byte_st_beat got be %b din %h want 1000 00000080", q_be[0], q_din[0]);
      end
      ref_model(1'b0, 2'b00, 1'b0, 12'h013, 32'h0, e_rd, e_err, e_lat);
      do_req(1'b0, 2'b00, 1'b0, 12'h013, 32'h0, g_rd, g_err, g_lat, g_wait, g_acc);
      n_tests++;
      if (g_rd !== 32'hFFFFFF80) begin
         n_fail++; $display("FAIL byte_ld_signed got %h want ffffff80", g_rd);
      end
      ref_model(1'b0, 2'b00, 1'b1, 12'h013, 32'h0, e_rd, e_err, e_lat);
      do_req(1'b0, 2'b00, 1'b1, 12'h013, 32'h0, g_rd, g_err, g_lat, g_wait, g_acc);
      n_tests++;
      if (g_rd !== 32'h00000080) begin
         n_fail++; $display("FAIL byte_ld_unsigned got %h want 00000080", g_rd);
      end
   endtask

   task automatic test_half();
      ref_model(1'b1, 2'b01, 1'b0, 12'h022, 32'h8001, e_rd, e_err, e_lat);
      do_req(1'b1, 2'b01, 1'b0, 12'h022, 32'h8001, g_rd, g_err, g_lat, g_wait, g_acc);
      n_tests++;
      if (q_be.size() != 1) begin
         n_fail++; $display("FAIL half_st_beats got %0d want 1", q_be.size());
      end else if ({q_be[0], q_din[0]} !== {4'b1100, 32'h00008001}) begin
         n_fail++; $display("FAIL half_st_beat got be %b din %h want 1100 00008001", q_be[0], q_din[0]);
      end
      ref_model(1'b0, 2'b01, 1'b0, 12'h022, 32'h0, e_rd, e_err, e_lat);
      do_req(1'b0, 2'b01, 1'b0, 12'h022, 32'h0, g_rd, g_err, g_lat, g_wait, g_acc);
      n_tests++;
      if (g_rd !== 32'hFFFF8001) begin
         n_fail++; $display("FAIL half_ld_signed got %h want ffff8001", g_rd);
      end
   endtask

   task automatic test_misaligned();
      logic [9:0]  ea [4] = '{10'h0, 10'h1, 10'h1, 10'h1};
      logic [3:0]  eb [4] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
      logic [31:0] ed [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
      ref_model(1'b1, 2'b10, 1'b0, 12'h003, 32'h44332211, e_rd, e_err, e_lat);
      do_req(1'b1, 2'b10, 1'b0, 12'h003, 32'h44332211, g_rd, g_err, g_lat, g_wait, g_acc);
      n_tests++;
      if (q_be.size() != 4) begin
         n_fail++; $display("FAIL mis_st_beats got %0d want 4", q_be.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_tests++;
            if ({q_addr[k], q_be[k], q_din[k]} !== {ea[k], eb[k], ed[k]}) begin
               n_fail++;
               $display("FAIL mis_st_beat%0d got addr %h be %b din %h want %h %b %h",
                        k, q_addr[k], q_be[k], q_din[k], ea[k], eb[k], ed[k]);
            end
         end
      end
      ref_model(1'b0, 2'b10, 1'b0, 12'h003, 32'h0, e_rd, e_err, e_lat);
      do_req(1'b0, 2'b10, 1'b0, 12'h003, 32'h0, g_rd, g_err, g_lat, g_wait, g_acc);
      n_tests++;
      if (g_rd !== 32'h44332211 || g_lat != 5) begin
         n_fail++; $display("FAIL mis_ld got %h lat %0d want 44332211 lat 5", g_rd, g_lat);
      end
   endtask

   task automatic test_errors();
      logic [1:0]  sz [4] = '{2'b10, 2'b01, 2'b11, 2'b11};
      logic [11:0] ad [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h123};
      for (int i = 0; i < 4; i++) begin
         do_req(i[0], sz[i], 1'b0, ad[i], 32'hA5A5A5A5, g_rd, g_err, g_lat, g_wait, g_acc);
         n_tests++;
         if (g_err !== 1'b1 || g_lat != 1 || g_rd !== 32'h0 || n_we != 0 || q_be.size() != 0) begin
            n_fail++;
            $display("FAIL err_case%0d got err %b lat %0d rdata %h we %0d beats %0d want 1 1 0 0 0",
                     i, g_err, g_lat, g_rd, n_we, q_be.size());
         end
      end
   endtask

   task automatic test_back_to_back();
      int first_acc;
      ref_model(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, e_rd, e_err, e_lat);
      do_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, g_rd, g_err, g_lat, g_wait, g_acc);
      first_acc = g_acc;
      ref_model(1'b0, 2'b00, 1'b1, 12'h013, 32'h0, e_rd, e_err, e_lat);
      do_req(1'b0, 2'b00, 1'b1, 12'h013, 32'h0, g_rd, g_err, g_lat, g_wait, g_acc);
      n_tests++;
      if (g_wait != 0 || g_acc - first_acc != 3) begin
         n_fail++; $display("FAIL b2b_spacing got wait %0d gap %0d want 0 3", g_wait, g_acc - first_acc);
      end
      n_tests++;
      if (g_rd !== e_rd) begin
         n_fail++; $display("FAIL b2b_data got %h want %h", g_rd, e_rd);
      end
   endtask

   task automatic test_random();
      logic        we, uns;
      logic [1:0]  size;
      logic [11:0] addr;
      logic [31:0] wd;
      int          r;
      for (int i = 0; i < 80; i++) begin
         we   = $urandom_range(0, 1);
         uns  = $urandom_range(0, 1);
         r    = $urandom_range(0, 9);
         size = (r == 0) ? 2'b11 : 2'(r % 3);
         addr = ($urandom_range(0, 3) == 0) ? 12'(12'hFF8 + $urandom_range(0, 7))
                                            : 12'(12'h200 + $urandom_range(0, 63));
         wd   = $urandom;
         ref_model(we, size, uns, addr, wd, e_rd, e_err, e_lat);
         do_req(we, size, uns, addr, wd, g_rd, g_err, g_lat, g_wait, g_acc);
         n_tests++;
         if (g_rd !== e_rd || g_err !== e_err || g_lat != e_lat) begin
            n_fail++;
            $display("FAIL rand%0d we %b sz %b addr %h got rd %h err %b lat %0d want %h %b %0d",
                     i, we, size, addr, g_rd, g_err, g_lat, e_rd, e_err, e_lat);
         end
         n_tests++;
         if ((e_err || !we) && n_we != 0) begin
            n_fail++; $display("FAIL rand%0d_spurious_we got %0d want 0", i, n_we);
         end
      end
   endtask

   task automatic test_reset_mid_access();
      int w = 0;
      int seen = 0;
      @(negedge clk);
      while (!req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 12'h101; req_wdata = 32'hA1B2C3D4;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_tests++;
      if ({req_ready, rsp_valid, dm_we} !== 3'b100) begin
         n_fail++; $display("FAIL rst_mid_ctl got %b want 100", {req_ready, rsp_valid, dm_we});
      end
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      n_tests++;
      if (seen != 0) begin
         n_fail++; $display("FAIL rst_mid_no_rsp got %0d pulses want 0", seen);
      end
      ref_mem[12'h101] = 8'hD4;
      ref_mem[12'h102] = 8'hC3;
      n_tests++;
      if ({tb_mem[12'h104], tb_mem[12'h103], tb_mem[12'h102], tb_mem[12'h101]} !==
          {ref_mem[12'h104], ref_mem[12'h103], ref_mem[12'h102], ref_mem[12'h101]}) begin
         n_fail++;
         $display("FAIL rst_mid_mem got %h%h%h%h want %h%h%h%h",
                  tb_mem[12'h104], tb_mem[12'h103], tb_mem[12'h102], tb_mem[12'h101],
                  ref_mem[12'h104], ref_mem[12'h103], ref_mem[12'h102], ref_mem[12'h101]);
      end
   endtask

   task automatic test_mem_sweep();
      int bad = 0;
      int first = -1;
      for (int i = 0; i < 4096; i++) begin
         if (tb_mem[i] !== ref_mem[i]) begin
            bad++;
            if (first < 0) first = i;
         end
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++; $display("FAIL mem_sweep got %0d differing bytes (first %h) want 0", bad, first);
      end
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_byte();
      test_half();
      test_misaligned();
      test_errors();
      test_back_to_back();
      test_random();
      test_reset_mid_access();
      test_mem_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
